// File: rtl/matrix_add8_sched_if.sv
// rtl/matrix_add8_sched_if.sv - handshake/tile bus bundle for matrix_add8_sched
//
// Purpose: groups the job-in, tile-issue, tile-result and job-out signals of
//          the 8x8 add sequencer into one bundle.
// Ports (slave = sequencer view):
//   in_valid/in_ready, A, B, m_bit1, m_bit2, flag  : job handshake and operands
//   t_valid, t_idx, t_A, t_B, t_m_bit1/2, t_flag    : quadrant issue to the tile
//   t_C                                             : tile result
//   out_valid/out_ready, C, job_cnt                 : result handshake and count
interface matrix_add8_sched_if #(
   parameter int width = 16
);
   logic                              in_valid;
   logic                              in_ready;
   logic [7:0][7:0][2*width-1:0]      A;
   logic [7:0][7:0][2*width-1:0]      B;
   logic [4:0]                        m_bit1;
   logic [4:0]                        m_bit2;
   logic                              flag;
   logic                              t_valid;
   logic [1:0]                        t_idx;
   logic [3:0][3:0][2*width-1:0]      t_A;
   logic [3:0][3:0][2*width-1:0]      t_B;
   logic [4:0]                        t_m_bit1;
   logic [4:0]                        t_m_bit2;
   logic                              t_flag;
   logic [3:0][3:0][2*width-1:0]      t_C;
   logic                              out_valid;
   logic                              out_ready;
   logic [7:0][7:0][2*width-1:0]      C;
   logic [15:0]                       job_cnt;

   modport slave (
      input  in_valid, A, B, m_bit1, m_bit2, flag, t_C, out_ready,
      output in_ready, t_valid, t_idx, t_A, t_B, t_m_bit1, t_m_bit2, t_flag,
             out_valid, C, job_cnt
   );

   modport master (
      output in_valid, A, B, m_bit1, m_bit2, flag, t_C, out_ready,
      input  in_ready, t_valid, t_idx, t_A, t_B, t_m_bit1, t_m_bit2, t_flag,
             out_valid, C, job_cnt
   );
endinterface

// File: rtl/matrix_add8_sched.sv
// rtl/matrix_add8_sched.sv - time-multiplexes one 4x4 tile adder over an 8x8 add job
//
// Purpose: accepts an 8x8 A/B job, issues the four quadrant pairs to a shared
//          tile adder on consecutive cycles, collects the ADD_LAT-delayed
//          results into C and holds C until downstream takes it.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-high
//   bus  : matrix_add8_sched_if.slave (job in, tile issue/result, job out)
module matrix_add8_sched #(
   parameter int width   = 16,
   parameter int ADD_LAT = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   matrix_add8_sched_if.slave   bus
);
   localparam int EW = 2 * width;

   typedef logic [EW-1:0]  elem_t;
   typedef elem_t [3:0][3:0] tile_t;
   typedef elem_t [7:0][7:0] mat_t;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t                     state_q, state_d;
   mat_t                       a_q, b_q, c_q;
   tile_t                      t_a_q, t_b_q;
   logic                       t_valid_q;
   logic [1:0]                 t_idx_q;
   logic [4:0]                 m_bit1_q, m_bit2_q;
   logic                       flag_q;
   logic [15:0]                job_cnt_q;
   // in-flight tracker: stage k holds the tile issued k+1 cycles ago
   logic [ADD_LAT-1:0]         pv_q;
   logic [ADD_LAT-1:0][1:0]    pidx_q;
   logic                       cap;
   logic [1:0]                 cap_idx;

   // quadrant q: row block = q[1], column block = q[0]
   function automatic tile_t quad(input mat_t m, input logic [1:0] q);
      tile_t t;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            t[r][c] = m[{q[1], r[1:0]}][{q[0], c[1:0]}];
      return t;
   endfunction

   assign cap     = pv_q[ADD_LAT-1];
   assign cap_idx = pidx_q[ADD_LAT-1];

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.in_valid)              state_d = RUN;
         RUN:     if (t_idx_q == 2'd3)           state_d = DRAIN;
         DRAIN:   if (cap && cap_idx == 2'd3)    state_d = DONE;
         DONE:    if (bus.out_ready)             state_d = IDLE;
         default:                                state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         c_q       <= '0;
         t_a_q     <= '0;
         t_b_q     <= '0;
         t_valid_q <= 1'b0;
         t_idx_q   <= 2'd0;
         m_bit1_q  <= 5'd0;
         m_bit2_q  <= 5'd0;
         flag_q    <= 1'b0;
         job_cnt_q <= 16'd0;
         pv_q      <= '0;
         pidx_q    <= '0;
      end else begin
         state_q   <= state_d;
         pv_q[0]   <= t_valid_q;
         pidx_q[0] <= t_idx_q;
         for (int k = 1; k < ADD_LAT; k++) begin
            pv_q[k]   <= pv_q[k-1];
            pidx_q[k] <= pidx_q[k-1];
         end
         if (cap) begin
            for (int r = 0; r < 4; r++)
               for (int c = 0; c < 4; c++)
                  c_q[{cap_idx[1], r[1:0]}][{cap_idx[0], c[1:0]}] <= bus.t_C[r][c];
         end
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  a_q       <= bus.A;
                  b_q       <= bus.B;
                  m_bit1_q  <= bus.m_bit1;
                  m_bit2_q  <= bus.m_bit2;
                  flag_q    <= bus.flag;
                  // quadrant 0 comes straight from the bus so it issues the next cycle
                  t_a_q     <= quad(bus.A, 2'd0);
                  t_b_q     <= quad(bus.B, 2'd0);
                  t_valid_q <= 1'b1;
                  t_idx_q   <= 2'd0;
               end
            end
            RUN: begin
               if (t_idx_q == 2'd3) begin
                  t_valid_q <= 1'b0;
               end else begin
                  t_idx_q <= t_idx_q + 2'd1;
                  t_a_q   <= quad(a_q, t_idx_q + 2'd1);
                  t_b_q   <= quad(b_q, t_idx_q + 2'd1);
               end
            end
            DONE: begin
               if (bus.out_ready) job_cnt_q <= job_cnt_q + 16'd1;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.t_valid   = t_valid_q;
   assign bus.t_idx     = t_idx_q;
   assign bus.t_A       = t_a_q;
   assign bus.t_B       = t_b_q;
   assign bus.t_m_bit1  = m_bit1_q;
   assign bus.t_m_bit2  = m_bit2_q;
   assign bus.t_flag    = flag_q;
   assign bus.C         = c_q;
   assign bus.job_cnt   = job_cnt_q;
endmodule

// File: tb/tb_matrix_add8_sched.sv
// tb/tb_matrix_add8_sched.sv - self-checking bench for matrix_add8_sched
module tb_matrix_add8_sched;
   typedef logic [7:0][7:0][31:0] mat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   mat_t exp_q[$];
   mat_t last_exp;
   mat_t zero_m = '0;

   always #5 clk = ~clk;

   matrix_add8_sched_if #(.width(16)) m1();
   matrix_add8_sched_if #(.width(16)) m4();

   matrix_add8_sched #(.width(16), .ADD_LAT(1)) d1 (.clk(clk), .rst(rst), .bus(m1.slave));
   matrix_add8_sched #(.width(16), .ADD_LAT(4)) d4 (.clk(clk), .rst(rst), .bus(m4.slave));

   // tile adder models: elementwise sum, ADD_LAT cycles after issue
   always @(posedge clk)
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            m1.t_C[r][c] <= m1.t_A[r][c] + m1.t_B[r][c];

   logic [3:0][3:0][3:0][31:0] p4;
   always @(posedge clk) begin
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            p4[0][r][c] <= m4.t_A[r][c] + m4.t_B[r][c];
      for (int k = 1; k < 4; k++) p4[k] <= p4[k-1];
   end
   assign m4.t_C = p4[3];

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_mat(input string tag, input mat_t got, input mat_t exp);
      for (int r = 0; r < 8; r++) check($sformatf("%s_row%0d", tag, r), got[r], exp[r]);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic mat_t ramp(input int mul);
      mat_t m;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++) m[i][j] = 32'(mul * (8 * i + j));
      return m;
   endfunction

   function automatic mat_t rnd();
      mat_t m;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++) m[i][j] = $urandom;
      return m;
   endfunction

   function automatic mat_t madd(input mat_t a, input mat_t b);
      mat_t m;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++) m[i][j] = a[i][j] + b[i][j];
      return m;
   endfunction

   // one job on the ADD_LAT=1 instance; returns in the cycle out_valid is first seen
   task automatic job1(input mat_t a, input mat_t b, input mat_t exp);
      int   n;
      bit   seen;
      mat_t e;
      m1.A = a; m1.B = b; m1.m_bit1 = 5'd17; m1.m_bit2 = 5'd2; m1.flag = 1'b0;
      m1.in_valid = 1'b1;
      exp_q.push_back(exp);
      n = 0; seen = 1'b0;
      while (!seen && n < 40) begin
         tick();
         n++;
         if (n == 1) begin
            m1.in_valid = 1'b0; m1.A = '0; m1.B = '0;
            m1.m_bit1 = 5'd0; m1.m_bit2 = 5'd0; m1.flag = 1'b1;
         end
         if (n <= 4) begin
            check("t_valid", m1.t_valid, 1);
            check("t_idx", m1.t_idx, 256'(n - 1));
            check("t_cfg", {m1.t_m_bit1, m1.t_m_bit2, m1.t_flag}, {5'd17, 5'd2, 1'b0});
         end
         if (n == 2) begin
            check("t_A_q1_00", m1.t_A[0][0], a[0][4]);
            check("t_B_q1_00", m1.t_B[0][0], b[0][4]);
         end
         if (n == 5) check("t_valid_off", m1.t_valid, 0);
         seen = m1.out_valid;
      end
      check("latency_lat1", 256'(n), 256'(6));
      e = exp_q.pop_front();
      last_exp = e;
      check_mat("C1", m1.C, e);
   endtask

   initial begin
      mat_t a, b, e;
      int   n;
      bit   seen;

      m1.in_valid = 1'b0; m1.A = '0; m1.B = '0; m1.m_bit1 = '0; m1.m_bit2 = '0; m1.flag = 1'b0;
      m1.out_ready = 1'b1;
      m4.in_valid = 1'b0; m4.A = '0; m4.B = '0; m4.m_bit1 = '0; m4.m_bit2 = '0; m4.flag = 1'b0;
      m4.out_ready = 1'b1;

      // reset state
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("rst_in_ready", m1.in_ready, 1);
      check("rst_t_valid", m1.t_valid, 0);
      check("rst_t_idx", m1.t_idx, 0);
      check("rst_out_valid", m1.out_valid, 0);
      check("rst_job_cnt", m1.job_cnt, 0);
      check("rst_t_A", m1.t_A[0], 0);
      check("rst_t_cfg", {m1.t_m_bit1, m1.t_m_bit2, m1.t_flag}, 0);
      check_mat("rst_C", m1.C, zero_m);

      // ramp job, ADD_LAT=1, out_ready=1
      job1(ramp(1), ramp(256), ramp(257));
      tick();
      check("j1_out_valid_drop", m1.out_valid, 0);
      check("j1_in_ready", m1.in_ready, 1);
      check("j1_job_cnt", m1.job_cnt, 1);

      // backpressure: out_ready low, in_valid toggled with fresh data
      m1.out_ready = 1'b0;
      a = rnd(); b = rnd();
      job1(a, b, madd(a, b));
      for (int k = 0; k < 10; k++) begin
         m1.in_valid = k[0]; m1.A = rnd(); m1.B = rnd();
         tick();
         check("bp_in_ready", m1.in_ready, 0);
         check("bp_t_valid", m1.t_valid, 0);
         check("bp_out_valid", m1.out_valid, 1);
      end
      check_mat("bp_C", m1.C, last_exp);
      m1.in_valid = 1'b0; m1.out_ready = 1'b1;
      tick();
      check("bp_out_valid_drop", m1.out_valid, 0);
      check("bp_in_ready_after", m1.in_ready, 1);
      check("bp_job_cnt", m1.job_cnt, 2);
      check("bp_C_kept_row7", m1.C[7], last_exp[7]);

      // ADD_LAT=4 with config, config changed right after accept
      a = rnd(); b = rnd();
      m4.A = a; m4.B = b; m4.m_bit1 = 5'd9; m4.m_bit2 = 5'd3; m4.flag = 1'b1;
      m4.in_valid = 1'b1;
      exp_q.push_back(madd(a, b));
      n = 0; seen = 1'b0;
      while (!seen && n < 40) begin
         tick();
         n++;
         if (n == 1) begin
            m4.in_valid = 1'b0; m4.A = rnd(); m4.B = rnd();
            m4.m_bit1 = 5'd30; m4.m_bit2 = 5'd12; m4.flag = 1'b0;
         end
         if (n <= 4) begin
            check("l4_t_valid", m4.t_valid, 1);
            check("l4_t_idx", m4.t_idx, 256'(n - 1));
            check("l4_t_cfg", {m4.t_m_bit1, m4.t_m_bit2, m4.t_flag}, {5'd9, 5'd3, 1'b1});
         end
         seen = m4.out_valid;
      end
      check("latency_lat4", 256'(n), 256'(9));
      e = exp_q.pop_front();
      check_mat("C4", m4.C, e);
      tick();
      check("l4_job_cnt", m4.job_cnt, 1);

      // reset in the cycle t_idx=2 is issued
      m1.A = ramp(3); m1.B = ramp(5); m1.in_valid = 1'b1;
      n = 0;
      while (n < 3) begin
         tick();
         n++;
         if (n == 1) m1.in_valid = 1'b0;
      end
      check("ab_t_idx2", m1.t_idx, 2);
      rst = 1'b1;
      tick();
      check("ab_t_valid", m1.t_valid, 0);
      check("ab_out_valid", m1.out_valid, 0);
      check("ab_in_ready", m1.in_ready, 1);
      check_mat("ab_C", m1.C, zero_m);
      rst = 1'b0;
      repeat (8) tick();
      check_mat("ab_C_late", m1.C, zero_m);
      check("ab_out_valid_late", m1.out_valid, 0);

      // job counter wrap
      force d1.job_cnt_q = 16'hFFFF;
      tick();
      release d1.job_cnt_q;
      tick();
      check("wrap_pre", m1.job_cnt, 16'hFFFF);
      job1(ramp(7), ramp(9), ramp(16));
      tick();
      check("wrap_job_cnt", m1.job_cnt, 16'h0000);

      check("sb_empty", 256'(exp_q.size()), 256'(0));
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
